doce_cfg_loader: RTL and testbench

AXI-Lite master that programs and verifies the DoCE MAC/IP address register block. On a start pulse it latches three 48-bit MAC IDs and one IPv4 address, then issues seven AXI-Lite writes. It follows them with seven read-backs, compares each read against the written value, and reports done/error status. It sits between the board-bring-up controller and the AXI-Lite slave port of the address register block.

---
 rtl/doce_cfg_loader.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_doce_cfg_loader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/doce_cfg_loader.sv
// doce_cfg_loader
//   AXI-Lite master that programs the DoCE MAC/IP address register block and
//   then reads every register back to confirm the values stuck.
//
//   A start pulse latches three 48-bit MAC IDs and one IPv4 address. The loader
//   then writes seven 32-bit registers, reads the same seven back and compares
//   each one with the value it wrote. A one-cycle done pulse ends every run.
//   At that point err/err_code/err_idx describe the first failure, if any.
//
//   Register table (address BASE_ADDR + 4*idx):
//     0: host[31:0]   1: {16'h0, host[47:32]}
//     2: dev[31:0]    3: {16'h0, dev[47:32]}
//     4: doce[31:0]   5: {16'h0, doce[47:32]}
//     6: ip
//
// Ports
//   axi_lite_aclk, axi_lite_areset       clock, async active-high reset
//   start                                one-cycle request, ignored while busy
//   host_mac_id/dev_mac_id/doce_mac_id   48-bit values to program
//   doce_ip_addr                         32-bit value to program
//   busy, done                           sequence in flight / end-of-run pulse
//   err, err_code, err_idx               sticky failure flag, cause, register
//                                        err_code: 1 bad resp, 2 mismatch,
//                                        3 timeout
//   m_axi_lite_*                         AXI-Lite master (AW, W, B, AR, R)
module doce_cfg_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        axi_lite_aclk,
    input  logic        axi_lite_areset,
    input  logic        start,
    input  logic [47:0] host_mac_id,
    input  logic [47:0] dev_mac_id,
    input  logic [47:0] doce_mac_id,
    input  logic [31:0] doce_ip_addr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [2:0]  err_idx,
    output logic        m_axi_lite_awvalid,
    output logic [31:0] m_axi_lite_awaddr,
    input  logic        m_axi_lite_awready,
    output logic        m_axi_lite_wvalid,
    output logic [31:0] m_axi_lite_wdata,
    output logic [3:0]  m_axi_lite_wstrb,
    input  logic        m_axi_lite_wready,
    input  logic        m_axi_lite_bvalid,
    input  logic [1:0]  m_axi_lite_bresp,
    output logic        m_axi_lite_bready,
    output logic        m_axi_lite_arvalid,
    output logic [31:0] m_axi_lite_araddr,
    input  logic        m_axi_lite_arready,
    input  logic        m_axi_lite_rvalid,
    input  logic [31:0] m_axi_lite_rdata,
    input  logic [1:0]  m_axi_lite_rresp,
    output logic        m_axi_lite_rready
);

    localparam int            TW    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]    LAST_IDX = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        FIN     = 3'd5
    } state_t;

    state_t        state;
    logic [47:0]   host_q;
    logic [47:0]   dev_q;
    logic [47:0]   doce_q;
    logic [31:0]   ip_q;
    logic [2:0]    idx;
    logic [TW-1:0] timer;
    // Failure cause/index are collected here and published together with done.
    logic [1:0]    fail_code;
    logic [2:0]    fail_idx;

    logic [2:0]    idx_nxt;
    logic [31:0]   cur_word;
    logic [31:0]   nxt_word;
    logic          aw_ok;
    logic          w_ok;
    logic          progress;
    logic          in_axi;

    // Register word for a given index; unused indices yield zero.
    function automatic logic [31:0] reg_word(input logic [2:0]  i,
                                             input logic [47:0] h,
                                             input logic [47:0] d,
                                             input logic [47:0] c,
                                             input logic [31:0] a);
        case (i)
            3'd0:    return h[31:0];
            3'd1:    return {16'h0000, h[47:32]};
            3'd2:    return d[31:0];
            3'd3:    return {16'h0000, d[47:32]};
            3'd4:    return c[31:0];
            3'd5:    return {16'h0000, c[47:32]};
            3'd6:    return a;
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] reg_addr(input logic [2:0] i);
        return BASE_ADDR + {27'd0, i, 2'b00};
    endfunction

    assign m_axi_lite_bready = (state == WR_RESP);
    assign m_axi_lite_rready = (state == RD_RESP);

    // Per-state progress decode: any state-advancing handshake stops the timeout.
    always_comb begin
        idx_nxt  = idx + 3'd1;
        cur_word = reg_word(idx, host_q, dev_q, doce_q, ip_q);
        nxt_word = reg_word(idx_nxt, host_q, dev_q, doce_q, ip_q);
        // A channel is finished once its valid has dropped or is handshaking now.
        aw_ok    = !m_axi_lite_awvalid || m_axi_lite_awready;
        w_ok     = !m_axi_lite_wvalid || m_axi_lite_wready;
        case (state)
            WR_REQ:  begin progress = aw_ok && w_ok;                              in_axi = 1'b1; end
            WR_RESP: begin progress = m_axi_lite_bvalid;                          in_axi = 1'b1; end
            RD_REQ:  begin progress = m_axi_lite_arvalid && m_axi_lite_arready;   in_axi = 1'b1; end
            RD_RESP: begin progress = m_axi_lite_rvalid;                          in_axi = 1'b1; end
            default: begin progress = 1'b0;                                       in_axi = 1'b0; end
        endcase
    end

    // Sequencer FSM with all AXI request and status outputs registered.
    always_ff @(posedge axi_lite_aclk or posedge axi_lite_areset) begin
        if (axi_lite_areset) begin
            state              <= IDLE;
            host_q             <= 48'h0;
            dev_q              <= 48'h0;
            doce_q             <= 48'h0;
            ip_q               <= 32'h0;
            idx                <= 3'd0;
            timer              <= '0;
            fail_code          <= 2'd0;
            fail_idx           <= 3'd0;
            busy               <= 1'b0;
            done               <= 1'b0;
            err                <= 1'b0;
            err_code           <= 2'd0;
            err_idx            <= 3'd0;
            m_axi_lite_awvalid <= 1'b0;
            m_axi_lite_awaddr  <= 32'h0;
            m_axi_lite_wvalid  <= 1'b0;
            m_axi_lite_wdata   <= 32'h0;
            m_axi_lite_wstrb   <= 4'h0;
            m_axi_lite_arvalid <= 1'b0;
            m_axi_lite_araddr  <= 32'h0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        host_q             <= host_mac_id;
                        dev_q              <= dev_mac_id;
                        doce_q             <= doce_mac_id;
                        ip_q               <= doce_ip_addr;
                        idx                <= 3'd0;
                        timer              <= '0;
                        fail_code          <= 2'd0;
                        fail_idx           <= 3'd0;
                        err                <= 1'b0;
                        err_code           <= 2'd0;
                        err_idx            <= 3'd0;
                        busy               <= 1'b1;
                        // First write goes out straight from the inputs so that
                        // awvalid/wvalid appear in the cycle after start.
                        m_axi_lite_awvalid <= 1'b1;
                        m_axi_lite_awaddr  <= reg_addr(3'd0);
                        m_axi_lite_wvalid  <= 1'b1;
                        m_axi_lite_wdata   <= reg_word(3'd0, host_mac_id, dev_mac_id,
                                                       doce_mac_id, doce_ip_addr);
                        m_axi_lite_wstrb   <= 4'hF;
                        state              <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (progress) begin
                        m_axi_lite_awvalid <= 1'b0;
                        m_axi_lite_wvalid  <= 1'b0;
                        timer              <= '0;
                        state              <= WR_RESP;
                    end else begin
                        // AW and W may complete in different cycles.
                        if (m_axi_lite_awvalid && m_axi_lite_awready) begin
                            m_axi_lite_awvalid <= 1'b0;
                        end
                        if (m_axi_lite_wvalid && m_axi_lite_wready) begin
                            m_axi_lite_wvalid <= 1'b0;
                        end
                    end
                end
                WR_RESP: begin
                    if (progress) begin
                        timer <= '0;
                        if (m_axi_lite_bresp != 2'b00) begin
                            fail_code <= 2'd1;
                            fail_idx  <= idx;
                            state     <= FIN;
                        end else if (idx == LAST_IDX) begin
                            idx                <= 3'd0;
                            m_axi_lite_arvalid <= 1'b1;
                            m_axi_lite_araddr  <= reg_addr(3'd0);
                            state              <= RD_REQ;
                        end else begin
                            idx                <= idx_nxt;
                            m_axi_lite_awvalid <= 1'b1;
                            m_axi_lite_awaddr  <= reg_addr(idx_nxt);
                            m_axi_lite_wvalid  <= 1'b1;
                            m_axi_lite_wdata   <= nxt_word;
                            state              <= WR_REQ;
                        end
                    end
                end
                RD_REQ: begin
                    if (progress) begin
                        m_axi_lite_arvalid <= 1'b0;
                        timer              <= '0;
                        state              <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (progress) begin
                        timer <= '0;
                        if (m_axi_lite_rresp != 2'b00) begin
                            fail_code <= 2'd1;
                            fail_idx  <= idx;
                            state     <= FIN;
                        end else if (m_axi_lite_rdata != cur_word) begin
                            fail_code <= 2'd2;
                            fail_idx  <= idx;
                            state     <= FIN;
                        end else if (idx == LAST_IDX) begin
                            state <= FIN;
                        end else begin
                            idx                <= idx_nxt;
                            m_axi_lite_arvalid <= 1'b1;
                            m_axi_lite_araddr  <= reg_addr(idx_nxt);
                            state              <= RD_REQ;
                        end
                    end
                end
                FIN: begin
                    done     <= 1'b1;
                    busy     <= 1'b0;
                    err      <= (fail_code != 2'd0);
                    err_code <= fail_code;
                    err_idx  <= fail_idx;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // Stalled AXI state: count, and abort with every valid dropped when
            // the budget runs out. Overrides the partial-handshake updates above.
            if (in_axi && !progress) begin
                if (timer == TLAST) begin
                    fail_code          <= 2'd3;
                    fail_idx           <= idx;
                    m_axi_lite_awvalid <= 1'b0;
                    m_axi_lite_wvalid  <= 1'b0;
                    m_axi_lite_arvalid <= 1'b0;
                    state              <= FIN;
                end else begin
                    timer <= timer + TW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_doce_cfg_loader.sv
module tb_doce_cfg_loader;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [47:0] host, dev, doce;
    logic [31:0] ip;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [2:0]  err_idx;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    doce_cfg_loader #(.BASE_ADDR(32'h0000_0000), .TIMEOUT_CYCLES(TMO)) dut (
        .axi_lite_aclk(clk), .axi_lite_areset(rst), .start(start),
        .host_mac_id(host), .dev_mac_id(dev), .doce_mac_id(doce), .doce_ip_addr(ip),
        .busy(busy), .done(done), .err(err), .err_code(err_code), .err_idx(err_idx),
        .m_axi_lite_awvalid(awvalid), .m_axi_lite_awaddr(awaddr), .m_axi_lite_awready(awready),
        .m_axi_lite_wvalid(wvalid), .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb),
        .m_axi_lite_wready(wready), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bresp(bresp),
        .m_axi_lite_bready(bready), .m_axi_lite_arvalid(arvalid), .m_axi_lite_araddr(araddr),
        .m_axi_lite_arready(arready), .m_axi_lite_rvalid(rvalid), .m_axi_lite_rdata(rdata),
        .m_axi_lite_rresp(rresp), .m_axi_lite_rready(rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;

    // Slave fault knobs
    int          split_idx  = -1;
    int          bresp_idx  = -1;
    int          rdata_idx  = -1;
    logic [31:0] rdata_bad  = 32'h0;
    bit          no_arready = 1'b0;

    // Scoreboard
    typedef struct packed { logic e; logic [1:0] c; logic [2:0] i; } st_t;
    logic [31:0] q_aw[$];
    logic [31:0] q_w[$];
    logic [31:0] q_ar[$];
    st_t         q_st[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference: register i holds 32-bit slices of the MACs, then the IP.
    function automatic logic [31:0] model_word(input int i, input logic [47:0] h,
                                               input logic [47:0] d, input logic [47:0] c,
                                               input logic [31:0] a);
        logic [47:0] m;
        if (i == 6) return a;
        m = (i < 2) ? h : (i < 4) ? d : c;
        if (i % 2 == 0) return m[31:0];
        return 32'(m >> 32);
    endfunction

    task automatic push_expect(input logic [47:0] h, input logic [47:0] d,
                               input logic [47:0] c, input logic [31:0] a);
        st_t s;
        for (int i = 0; i < 7; i++) begin
            q_aw.push_back(32'(4 * i));
            q_w.push_back(model_word(i, h, d, c, a));
            if (i == bresp_idx) begin
                s = '{1'b1, 2'd1, 3'(i)}; q_st.push_back(s); return;
            end
        end
        if (no_arready) begin
            s = '{1'b1, 2'd3, 3'd0}; q_st.push_back(s); return;
        end
        for (int i = 0; i < 7; i++) begin
            q_ar.push_back(32'(4 * i));
            if (i == rdata_idx && rdata_bad != model_word(i, h, d, c, a)) begin
                s = '{1'b1, 2'd2, 3'(i)}; q_st.push_back(s); return;
            end
        end
        s = '{1'b0, 2'd0, 3'd0}; q_st.push_back(s);
    endtask

    // Slave model
    logic        aw_got, w_got, ar_got;
    int          aw_cnt, w_cnt;
    logic [2:0]  aw_a, ar_a;
    logic [31:0] w_d;
    logic [31:0] mem [0:7];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            awready <= 1'b0; wready <= 1'b0; bvalid <= 1'b0; bresp <= 2'b00;
            arready <= 1'b0; rvalid <= 1'b0; rresp <= 2'b00; rdata <= 32'h0;
            aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            aw_a <= 3'd0; ar_a <= 3'd0; w_d <= 32'h0;
        end else begin
            if (awvalid && awready) begin
                awready <= 1'b0; aw_got <= 1'b1; aw_a <= awaddr[4:2];
            end else if (awvalid && !aw_got) begin
                if (aw_cnt >= 0) awready <= 1'b1;
                else aw_cnt <= aw_cnt + 1;
            end
            if (wvalid && wready) begin
                wready <= 1'b0; w_got <= 1'b1; w_d <= wdata;
            end else if (wvalid && !w_got) begin
                if (w_cnt >= ((int'(awaddr[4:2]) == split_idx) ? 2 : 0)) wready <= 1'b1;
                else w_cnt <= w_cnt + 1;
            end
            if (bvalid && bready) begin
                bvalid <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; aw_cnt <= 0; w_cnt <= 0;
            end else if (aw_got && w_got && !bvalid) begin
                bvalid <= 1'b1;
                bresp  <= (int'(aw_a) == bresp_idx) ? 2'b10 : 2'b00;
                mem[aw_a] <= w_d;
            end
            if (arvalid && arready) begin
                arready <= 1'b0; ar_got <= 1'b1; ar_a <= araddr[4:2];
            end else if (arvalid && !ar_got && !arready && !no_arready) begin
                arready <= 1'b1;
            end
            if (rvalid && rready) begin
                rvalid <= 1'b0; ar_got <= 1'b0;
            end else if (ar_got && !rvalid) begin
                rvalid <= 1'b1;
                rresp  <= 2'b00;
                rdata  <= (int'(ar_a) == rdata_idx) ? rdata_bad : mem[ar_a];
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a handshake or done
    initial begin
        bit          done_prev;
        bit          w_hold;
        logic [31:0] w_prev;
        int          ar_run;
        int          ar_last;
        st_t         s;
        done_prev = 1'b0; w_hold = 1'b0; w_prev = 32'h0; ar_run = 0; ar_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                done_prev = 1'b0; w_hold = 1'b0; ar_run = 0;
            end else begin
                if (awvalid && awready) begin
                    check("aw_pending", q_aw.size() != 0, 1);
                    if (q_aw.size() != 0) check("awaddr", awaddr, q_aw.pop_front());
                end
                if (wvalid && wready) begin
                    check("w_pending", q_w.size() != 0, 1);
                    if (q_w.size() != 0) check("wdata", wdata, q_w.pop_front());
                    check("wstrb", wstrb, 4'hF);
                end
                if (arvalid && arready) begin
                    check("ar_pending", q_ar.size() != 0, 1);
                    if (q_ar.size() != 0) check("araddr", araddr, q_ar.pop_front());
                end
                if (split_idx >= 0) begin
                    if (w_hold) check("wdata_hold", {wvalid, wdata}, {1'b1, w_prev});
                    if (aw_got && !w_got) check("aw_dropped", awvalid, 0);
                end
                w_hold = wvalid && !wready;
                w_prev = wdata;
                if (arvalid) ar_run++;
                else begin
                    if (ar_run != 0) ar_last = ar_run;
                    ar_run = 0;
                end
                if (done) begin
                    check("done_pulse", done_prev, 0);
                    check("busy_at_done", busy, 0);
                    check("st_pending", q_st.size() != 0, 1);
                    if (q_st.size() != 0) begin
                        s = q_st.pop_front();
                        check("status", {err, err_code, err_idx}, s);
                    end
                    check("leftover", q_aw.size() + q_w.size() + q_ar.size(), 0);
                    if (no_arready) check("tmo_len", ar_last, TMO);
                    done_cnt++;
                end
                done_prev = done;
            end
        end
    end

    task automatic clear_knobs();
        split_idx = -1; bresp_idx = -1; rdata_idx = -1; rdata_bad = 32'h0; no_arready = 1'b0;
    endtask

    task automatic rand_vals(output logic [47:0] h, output logic [47:0] d,
                             output logic [47:0] c, output logic [31:0] a);
        h = 48'({$urandom(), $urandom()});
        d = 48'({$urandom(), $urandom()});
        c = 48'({$urandom(), $urandom()});
        a = $urandom();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ctrl"}, {busy, done, err, err_code, err_idx, awvalid, wvalid,
                               arvalid, bready, rready, wstrb}, 0);
        check({tag, "_addr"}, {awaddr, araddr}, 0);
        check({tag, "_wdata"}, wdata, 0);
    endtask

    task automatic pulse_start(input logic [47:0] h, input logic [47:0] d,
                               input logic [47:0] c, input logic [31:0] a);
        @(posedge clk); #1;
        host = h; dev = d; doce = c; ip = a; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_lat", {busy, awvalid, wvalid}, 3'b111);
        rand_vals(host, dev, doce, ip);
    endtask

    task automatic run_seq(input logic [47:0] h, input logic [47:0] d,
                           input logic [47:0] c, input logic [31:0] a, input bit poke);
        int base;
        int t;
        base = done_cnt;
        push_expect(h, d, c, a);
        pulse_start(h, d, c, a);
        if (poke) begin
            repeat (9) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        t = 0;
        while (done_cnt == base && t < 2000) begin @(posedge clk); t++; end
        check("done_seen", done_cnt != base, 1);
        repeat (3) @(posedge clk);
    endtask

    initial begin
        logic [47:0] h, d, c;
        logic [31:0] a;
        int          t;
        int          base;
        rst = 1'b1; start = 1'b0; host = 48'h0; dev = 48'h0; doce = 48'h0; ip = 32'h0;
        repeat (3) @(posedge clk);
        #1 check_reset_vals("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Default run with a stray start mid-sequence
        run_seq(48'hEEA0_DDCCBBAA, 48'hEEB0_11223344, 48'hEEC0_55667788, 32'h0A00_0001, 1'b1);
        check("err_after_pass", err, 0);

        // Split AW/W ready on idx 2
        split_idx = 2;
        rand_vals(h, d, c, a);
        run_seq(h, d, c, a, 1'b0);
        clear_knobs();

        // Readback mismatch on idx 3
        rdata_idx = 3; rdata_bad = 32'h0000B0EE;
        rand_vals(h, d, c, a);
        d[47:32] = 16'hEEB0;
        run_seq(h, d, c, a, 1'b0);
        check("err_sticky", err, 1);
        clear_knobs();

        // Error write response on idx 5
        bresp_idx = 5;
        rand_vals(h, d, c, a);
        run_seq(h, d, c, a, 1'b0);
        clear_knobs();

        // arready never arrives: timeout
        no_arready = 1'b1;
        rand_vals(h, d, c, a);
        run_seq(h, d, c, a, 1'b0);
        clear_knobs();
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset in the middle of WR_RESP for idx 2
        rand_vals(h, d, c, a);
        base = done_cnt;
        push_expect(h, d, c, a);
        pulse_start(h, d, c, a);
        t = 0;
        do begin @(negedge clk); t++; end while (!(bready && awaddr == 32'h8) && t < 500);
        check("reach_wr_resp", bready, 1);
        rst = 1'b1;
        #1 check_reset_vals("mid_reset");
        q_aw.delete(); q_w.delete(); q_ar.delete(); q_st.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        check("no_done_on_reset", done_cnt, base);
        rand_vals(h, d, c, a);
        run_seq(h, d, c, a, 1'b0);

        // Randomized runs with random fault choice
        for (int k = 0; k < 6; k++) begin
            clear_knobs();
            case ($urandom_range(0, 3))
                0: bresp_idx = $urandom_range(0, 6);
                1: begin rdata_idx = $urandom_range(0, 6); rdata_bad = $urandom(); end
                2: split_idx = $urandom_range(0, 6);
                default: ;
            endcase
            rand_vals(h, d, c, a);
            run_seq(h, d, c, a, k[0]);
        end
        clear_knobs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
